timer_dev: RTL



---
 rtl/timer_dev_pkg.sv | 33 +++
 rtl/timer_prescaler.sv | 28 ++
 rtl/timer_dev.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer_dev bridge device: register offsets, CTRL
// bit positions, mode encodings, FSM states and the HWInt line it drives.
package timer_dev_pkg;

  localparam logic [1:0] TIMER_CTRL     = 2'd0;
  localparam logic [1:0] TIMER_PRESET   = 2'd1;
  localparam logic [1:0] TIMER_COUNT    = 2'd2;
  localparam logic [1:0] TIMER_PRESCALE = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int TIMER_HWINT_BIT = 2;
  localparam int PRESCALE_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Only the exact 01 encoding reloads; 1x behaves as one-shot.
  function automatic logic is_reload(input logic [3:0] ctrl);
    return ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the timer: tick is high on the cycle the divider equals
// prescale; it restarts from zero whenever clear is asserted.
module timer_prescaler
  import timer_dev_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div;

  assign tick = (div == prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (clear) begin
      div <= '0;
    end else if (run) begin
      div <= tick ? '0 : div + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped programmable timer (CTRL/PRESET/COUNT) driving one HWInt line.
// Optional TIMER_PRESCALE_EN adds a PRESCALE register at address 3.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int unsigned       CNT_W        = 32,
  parameter logic [CNT_W-1:0]  RESET_PRESET = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq,
  output logic [1:0]  state_dbg
);

  state_t           state, state_nx;
  logic [3:0]       ctrl, ctrl_nx;
  logic [CNT_W-1:0] preset, count;
  logic             flag, flag_nx;
  logic             ctrl_wr, preset_wr, en, tick;
  logic             load_cnt, dec_cnt, set_flag, clr_flag, clr_en;

  assign ctrl_wr   = we && (addr == TIMER_CTRL);
  assign preset_wr = we && (addr == TIMER_PRESET);
  assign en        = ctrl[CTRL_EN];
  assign state_dbg = state;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
    end else if (we && (addr == TIMER_PRESCALE)) begin
      prescale <= din[PRESCALE_W-1:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_LOAD),
    .run      ((state == ST_CNT) && en),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    set_flag = 1'b0;
    clr_flag = 1'b0;
    clr_en   = 1'b0;
    case (state)
      ST_IDLE: if (en) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (en) begin
          load_cnt = 1'b1;
          state_nx = ST_CNT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_CNT: begin
        if (!en) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          if (count != '0) begin
            dec_cnt = 1'b1;
          end else begin
            set_flag = 1'b1;
            state_nx = ST_INT;
          end
        end
      end
      ST_INT: begin
        if (is_reload(ctrl)) begin
          clr_flag = 1'b1;
          state_nx = ST_LOAD;
        end else begin
          clr_en   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A bus write to CTRL beats the FSM's EN clear; a flag set beats the write's clear.
  always_comb begin
    ctrl_nx = ctrl;
    if (ctrl_wr) begin
      ctrl_nx = din[3:0];
    end else if (clr_en) begin
      ctrl_nx[CTRL_EN] = 1'b0;
    end
    flag_nx = flag;
    if (set_flag) begin
      flag_nx = 1'b1;
    end else if (ctrl_wr || clr_flag) begin
      flag_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      ctrl   <= '0;
      flag   <= 1'b0;
      irq    <= 1'b0;
      preset <= RESET_PRESET;
      count  <= '0;
    end else begin
      state <= state_nx;
      ctrl  <= ctrl_nx;
      flag  <= flag_nx;
      irq   <= flag_nx & ctrl_nx[CTRL_IM];
      if (preset_wr) preset <= din[CNT_W-1:0];
      if (load_cnt) begin
        count <= preset;
      end else if (dec_cnt) begin
        count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      TIMER_CTRL:   dout[3:0]       = ctrl;
      TIMER_PRESET: dout[CNT_W-1:0] = preset;
      TIMER_COUNT:  dout[CNT_W-1:0] = count;
`ifdef TIMER_PRESCALE_EN
      TIMER_PRESCALE: dout[PRESCALE_W-1:0] = prescale;
`endif
      default:      dout = '0;
    endcase
  end

endmodule
